// File: rtl/m_download_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_download_pkg
//  Description : Shared types and constants for the memory request download
//                path (flit reassembly into one memory request message).
//  Revision    : 1.0 - initial release
// ============================================================================
package m_download_pkg;

    // FSM encoding; 2'b11 is illegal and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int FLIT_W        = 16;
    localparam int MSG_W         = 176;
    localparam int FLITS_MAX_CAP = 10;
    localparam int HDR_FMAX_LSB  = 0;
    localparam int HDR_FMAX_W    = 4;

    // Header length fields above the message capacity are saturated
    function automatic logic [HDR_FMAX_W-1:0] clamp_fmax(input logic [HDR_FMAX_W-1:0] fmax);
        if (fmax > HDR_FMAX_W'(FLITS_MAX_CAP))
            return HDR_FMAX_W'(FLITS_MAX_CAP);
        else
            return fmax;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_download_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : m_download_gap_timer
//  Description : Idle-gap counter for message assembly. Counts cycles with no
//                flit transfer while running and flags the terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_download_gap_timer
    import m_download_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expire
);

    localparam logic [7:0] c_term = 8'(TIMEOUT_CYC);

    logic [7:0] r_gap;

    // Count idle cycles; restart on every transfer and whenever not running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap <= 8'd0;
        end else if (!i_run || i_kick) begin
            r_gap <= 8'd0;
        end else if (r_gap != c_term) begin
            r_gap <= r_gap + 8'd1;
        end
    end

    assign o_expire = i_run && (r_gap == c_term);

endmodule
`default_nettype wire

// File: rtl/m_req_download.sv
`default_nettype none
// ============================================================================
//  Module      : m_req_download
//  Description : Reassembles a stream of 16-bit flits from the ring download
//                FIFO into one 176-bit memory request message and holds it
//                until the memory node consumes it.
//                Optional macro M_REQ_DOWNLOAD_TIMEOUT_EN adds an idle-gap
//                abort while assembling (err_timeout pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module m_req_download #(
    parameter int FLIT_W      = 16,
    parameter int MSG_W       = 176,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              v_flit_in,
    output logic              down_fifo_rdy,
    output logic [MSG_W-1:0]  m_flits_req,
    output logic              v_m_flits_req,
    input  logic              m_req_rdy,
    output logic [1:0]        m_req_download_state,
    output logic              err_timeout
);

    import m_download_pkg::*;

    localparam int c_slots = MSG_W / FLIT_W;

    state_t                  r_state;
    logic [MSG_W-1:0]        r_msg;
    logic [3:0]              r_cnt;
    logic [3:0]              r_fmax;
    logic                    r_rdy;
    logic                    r_valid;
    logic                    r_err;

    logic                    w_xfer;
    logic                    w_expire;
    logic [HDR_FMAX_W-1:0]   w_hdr_fmax;

    assign w_xfer     = v_flit_in && r_rdy;
    assign w_hdr_fmax = clamp_fmax(flit_in[HDR_FMAX_LSB +: HDR_FMAX_W]);

`ifdef M_REQ_DOWNLOAD_TIMEOUT_EN
    m_download_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (r_state == ST_BUSY),
        .i_kick   (w_xfer),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_expire         = 1'b0;
`endif

    // Assembly FSM with registered handshake outputs and message register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_msg   <= '0;
            r_cnt   <= 4'd0;
            r_fmax  <= 4'd0;
            r_rdy   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rdy <= 1'b1;
                    if (w_xfer) begin
                        r_msg[MSG_W-1 -: FLIT_W] <= flit_in;
                        r_fmax <= w_hdr_fmax;
                        r_cnt  <= 4'd1;
                        if (w_hdr_fmax == 4'd0) begin
                            r_state <= ST_DONE;
                            r_rdy   <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_xfer) begin
                        for (int k = 1; k < c_slots; k++) begin
                            if (r_cnt == 4'(k))
                                r_msg[MSG_W-1-FLIT_W*k -: FLIT_W] <= flit_in;
                        end
                        if (r_cnt == r_fmax) begin
                            // last flit: keep cnt at flits_max, never past cap
                            r_state <= ST_DONE;
                            r_rdy   <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                        r_msg   <= '0;
                        r_cnt   <= 4'd0;
                        r_fmax  <= 4'd0;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (m_req_rdy) begin
                        r_state <= ST_IDLE;
                        r_msg   <= '0;
                        r_cnt   <= 4'd0;
                        r_fmax  <= 4'd0;
                        r_rdy   <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_msg   <= '0;
                    r_cnt   <= 4'd0;
                    r_fmax  <= 4'd0;
                    r_rdy   <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign down_fifo_rdy        = r_rdy;
    assign m_flits_req          = r_msg;
    assign v_m_flits_req        = r_valid;
    assign m_req_download_state = r_state;
    assign err_timeout          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_m_req_download.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_req_download
//  Description : Directed, table-driven self-checking bench for m_req_download.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_req_download;

    logic         clk;
    logic         rst;
    logic [15:0]  flit_in;
    logic         v_flit_in;
    logic         down_fifo_rdy;
    logic [175:0] m_flits_req;
    logic         v_m_flits_req;
    logic         m_req_rdy;
    logic [1:0]   m_req_download_state;
    logic         err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    m_req_download dut (
        .clk                  (clk),
        .rst                  (rst),
        .flit_in              (flit_in),
        .v_flit_in            (v_flit_in),
        .down_fifo_rdy        (down_fifo_rdy),
        .m_flits_req          (m_flits_req),
        .v_m_flits_req        (v_m_flits_req),
        .m_req_rdy            (m_req_rdy),
        .m_req_download_state (m_req_download_state),
        .err_timeout          (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [15:0]  flit;
        logic         mrdy;
        logic         e_rdy;
        logic         e_valid;
        logic [1:0]   e_state;
        logic         chk_msg;
        logic [175:0] e_msg;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input logic [15:0] flit, input logic mrdy,
                                input logic e_rdy, input logic e_valid, input logic [1:0] e_state,
                                input logic chk_msg, input logic [175:0] e_msg);
        vec_t t;
        t.v = v; t.flit = flit; t.mrdy = mrdy;
        t.e_rdy = e_rdy; t.e_valid = e_valid; t.e_state = e_state;
        t.chk_msg = chk_msg; t.e_msg = e_msg;
        return t;
    endfunction

    task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic v, input logic [15:0] f, input logic mr);
        v_flit_in = v;
        flit_in   = f;
        m_req_rdy = mr;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [175:0] m_a;
    logic [175:0] m_9;
    logic [175:0] m_11;
    logic [175:0] m_z;
    int           pulses;

    initial begin
        m_z  = '0;
        m_a  = {16'hA000, 160'h0};
        m_9  = {16'h1008, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                16'h0005, 16'h0006, 16'h0007, 16'h0008, 32'h0};
        m_11 = {16'h000F, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005,
                16'hB006, 16'hB007, 16'hB008, 16'hB009, 16'hB00A};

        // single-flit message
        vq.push_back(mk(0, 16'h0000, 0, 1, 0, S_IDLE, 1, m_z));
        vq.push_back(mk(1, 16'hA000, 0, 0, 1, S_DONE, 1, m_a));
        vq.push_back(mk(1, 16'h1234, 0, 0, 1, S_DONE, 1, m_a));
        vq.push_back(mk(0, 16'h0000, 1, 1, 0, S_IDLE, 1, m_z));
        // 9-flit message, back-to-back
        vq.push_back(mk(1, 16'h1008, 0, 1, 0, S_BUSY, 0, m_z));
        for (int i = 1; i <= 7; i++)
            vq.push_back(mk(1, 16'(i), 0, 1, 0, S_BUSY, 0, m_z));
        vq.push_back(mk(1, 16'h0008, 0, 0, 1, S_DONE, 1, m_9));
        // DONE held 5 cycles with flits offered
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1, 16'hFFFF, 0, 0, 1, S_DONE, 1, m_9));
        // accept cycle: offered flit must not be taken
        vq.push_back(mk(1, 16'hFFFF, 1, 1, 0, S_IDLE, 1, m_z));
        vq.push_back(mk(0, 16'h0000, 0, 1, 0, S_IDLE, 1, m_z));
        // clamped header: 11 flits total
        vq.push_back(mk(1, 16'h000F, 0, 1, 0, S_BUSY, 0, m_z));
        for (int i = 1; i <= 9; i++)
            vq.push_back(mk(1, 16'hB000 + 16'(i), 0, 1, 0, S_BUSY, 0, m_z));
        vq.push_back(mk(1, 16'hB00A, 0, 0, 1, S_DONE, 1, m_11));
        vq.push_back(mk(1, 16'hEEEE, 0, 0, 1, S_DONE, 1, m_11));
        vq.push_back(mk(0, 16'h0000, 1, 1, 0, S_IDLE, 1, m_z));

        rst = 1'b0; v_flit_in = 1'b0; flit_in = '0; m_req_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",   {175'h0, down_fifo_rdy}, 176'h0);
        chk("rst_valid", {175'h0, v_m_flits_req}, 176'h0);
        chk("rst_msg",   m_flits_req, m_z);
        chk("rst_state", {174'h0, m_req_download_state}, {174'h0, S_IDLE});
        chk("rst_err",   {175'h0, err_timeout}, 176'h0);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].v, vq[i].flit, vq[i].mrdy);
            chk($sformatf("v%0d_rdy", i),   {175'h0, down_fifo_rdy}, {175'h0, vq[i].e_rdy});
            chk($sformatf("v%0d_valid", i), {175'h0, v_m_flits_req}, {175'h0, vq[i].e_valid});
            chk($sformatf("v%0d_state", i), {174'h0, m_req_download_state}, {174'h0, vq[i].e_state});
            chk($sformatf("v%0d_err", i),   {175'h0, err_timeout}, 176'h0);
            if (vq[i].chk_msg)
                chk($sformatf("v%0d_msg", i), m_flits_req, vq[i].e_msg);
        end

        // asynchronous reset in BUSY after 3 of 6 flits
        step(1, 16'h0005, 0);
        step(1, 16'hC001, 0);
        step(1, 16'hC002, 0);
        chk("pre_rst_state", {174'h0, m_req_download_state}, {174'h0, S_BUSY});
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy",   {175'h0, down_fifo_rdy}, 176'h0);
        chk("arst_valid", {175'h0, v_m_flits_req}, 176'h0);
        chk("arst_msg",   m_flits_req, m_z);
        chk("arst_state", {174'h0, m_req_download_state}, {174'h0, S_IDLE});
        v_flit_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 16'h0000, 0);
        chk("post_rst_rdy", {175'h0, down_fifo_rdy}, 176'h1);
        step(1, 16'hA000, 0);
        chk("post_rst_valid", {175'h0, v_m_flits_req}, 176'h1);
        chk("post_rst_msg",   m_flits_req, m_a);
        step(0, 16'h0000, 1);
        chk("post_rst_idle", {174'h0, m_req_download_state}, {174'h0, S_IDLE});

        // idle gap in BUSY
        step(1, 16'h0003, 0);
        step(1, 16'h1111, 0);
        pulses = 0;
`ifdef M_REQ_DOWNLOAD_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            step(0, 16'h0000, 0);
            if (err_timeout) pulses++;
        end
        chk("tmo_pulses", 176'(pulses), 176'd1);
        chk("tmo_state", {174'h0, m_req_download_state}, {174'h0, S_IDLE});
        chk("tmo_msg", m_flits_req, m_z);
`else
        for (int i = 0; i < 260; i++) begin
            step(0, 16'h0000, 0);
            if (err_timeout) pulses++;
        end
        chk("gap_pulses", 176'(pulses), 176'd0);
        chk("gap_state", {174'h0, m_req_download_state}, {174'h0, S_BUSY});
        chk("gap_msg", m_flits_req, {16'h0003, 16'h1111, 144'h0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_req_download.md
# m_req_download

Receive-side counterpart of the memory reply upload path. Accepts a stream of 16-bit flits from the ring's download FIFO and reassembles them into one 176-bit message for the memory node. It then holds the message until the memory node consumes it. It sits between the ring download FIFO and the memory-side request handler, and exposes a busy/idle state to the node's arbiter.

## Interface
Parameters:
- FLIT_W, 16, flit width in bits
- MSG_W, 176, assembled message width (11 flits)
- TIMEOUT_CYC, 255, idle-gap limit in cycles while assembling (used only with the timeout feature)

Ports:
- clk  input  1  clock; all state on the rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- flit_in  input  16  incoming flit
- v_flit_in  input  1  flit_in valid
- down_fifo_rdy  output  1  block can accept a flit this cycle
- m_flits_req  output  176  assembled message; flit 0 in [175:160], flit k in [175-16k:160-16k]
- v_m_flits_req  output  1  message complete and valid
- m_req_rdy  input  1  consumer accepts the message this cycle
- m_req_download_state  output  2  current FSM state
- err_timeout  output  1  one-cycle pulse on assembly abort

## Operation
- Flit handshake: a flit transfers when v_flit_in && down_fifo_rdy.
- down_fifo_rdy = 1 in IDLE and BUSY, 0 in DONE.
- Header flit is the first flit transferred in IDLE. Its bits [3:0] give flits_max, the index of the last flit.
- flits_max values 11..15 are clamped to 10.
- The header is stored in slot 0. flits_max is latched into flits_max_reg, and cnt is set to 1.
- If flits_max == 0: IDLE -> DONE. Otherwise IDLE -> BUSY.
- BUSY: each transferred flit is written to slot cnt, then cnt increments.
  - When the transferred flit has cnt == flits_max_reg: BUSY -> DONE.
- DONE: v_m_flits_req = 1 and m_flits_req is held stable.
  - On m_req_rdy: DONE -> IDLE, and the message register, cnt and flits_max_reg clear to 0.
- Slots beyond flits_max_reg read 0. The message register is cleared on entry to IDLE, never partially stale.
- State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10. 2'b11 is illegal and recovers to IDLE on the next edge.
- cnt is 4 bits and never exceeds 10, so there is no wrap.

## Timing
- Reset values: down_fifo_rdy=0 while rst=0, then 1 once in IDLE. v_m_flits_req=0, m_flits_req=0, m_req_download_state=IDLE, err_timeout=0. cnt and flits_max_reg are 0.
- Reset mid-assembly or mid-DONE discards the message immediately (asynchronous).
- Latency from the transfer of flit flits_max to v_m_flits_req=1 is one cycle (registered).
- DONE -> IDLE takes one cycle after m_req_rdy. down_fifo_rdy is 1 again in the following cycle, so no flit is accepted in the accept cycle.
- v_m_flits_req does not depend combinationally on m_req_rdy. down_fifo_rdy does not depend combinationally on v_flit_in.
- A gap (v_flit_in=0) in BUSY holds state indefinitely, unless the timeout feature is compiled in.

## Configuration
- Macro: M_REQ_DOWNLOAD_TIMEOUT_EN.
- With the macro:
  - An 8-bit gap counter runs in BUSY, resets on every flit transfer and clears outside BUSY.
  - When the counter reaches TIMEOUT_CYC, the FSM goes BUSY -> IDLE, all registers clear, and err_timeout pulses high for 1 cycle.
- Without the macro: no counter is present, err_timeout is tied 0, and BUSY waits forever.

## Structure
- Shared package m_download_pkg:
  - state typedef (IDLE/BUSY/DONE)
  - FLIT_W and MSG_W
  - FLITS_MAX_CAP=10
  - header field position HDR_FMAX_LSB=0 / width 4
- Sub-module m_download_gap_timer: gap counter plus terminal-count compare. Instantiated only under M_REQ_DOWNLOAD_TIMEOUT_EN.

## Test plan
- Reset then a single-flit message, header 16'hA000: v_m_flits_req=1 next cycle, m_flits_req[175:160]=16'hA000, rest 0, down_fifo_rdy=0. After m_req_rdy, state=IDLE.
- 9-flit message, header 16'h1008 then 16'h0001..16'h0008 back-to-back: DONE after the 9th flit. Slots 1..8 hold 0001..0008, bits [31:0] are 0.
- Header 16'h000F (flits_max clamped to 10), 11 flits total: DONE after exactly 11 transfers, and a 12th offered flit is not accepted.
- DONE held 5 cycles with m_req_rdy=0 while v_flit_in=1: no flit is taken and m_flits_req is unchanged. m_req_rdy=1 then returns the block to IDLE.
- rst pulsed low in BUSY after 3 of 6 flits: all outputs return to reset values immediately, and the next header starts a clean message.
- With M_REQ_DOWNLOAD_TIMEOUT_EN: header 16'h0003 and 1 flit, then 255 idle cycles -> err_timeout pulses once and state=IDLE. Without the macro the same stimulus leaves state=BUSY.
